// File: rtl/servo_pkg.sv
// servo_pkg: shared clock-derived defaults and the pulse-length helper for servo_bank.
package servo_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned FRAME_CYC = CLK_HZ / 50;     // 20 ms frame
  localparam int unsigned MIN_PULSE = CLK_HZ / 1000;   // 1 ms at position 0
  localparam int unsigned STEP_CYC  = 196;
  localparam int unsigned SLEW_STEP = 4;
  localparam int unsigned PL_W      = 32;

  // Pulse length in cycles for a position; evaluated at full 32-bit width.
  function automatic logic [PL_W-1:0] pulse_len_f(input logic [PL_W-1:0] pos,
                                                   input logic [PL_W-1:0] min_pulse,
                                                   input logic [PL_W-1:0] step_cyc);
    return min_pulse + pos * step_cyc;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// servo_channel: one servo output - target and current position, pulse length and PWM compare.
// With SERVO_SLEW_EN defined the current position moves at most SLEW_STEP per frame.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned POS_W       = 8,
  parameter int unsigned CTR_W       = 20,
  parameter int unsigned MIN_PULSE_C = 50_000,
`ifdef SERVO_SLEW_EN
  parameter int unsigned SLEW_STEP_C = 4,
`endif
  parameter int unsigned STEP_CYC_C  = 196
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boundary,
  input  logic             wr_en,
  input  logic [POS_W-1:0] wr_pos,
  input  logic             en_in,
  input  logic [CTR_W-1:0] ctr,
  output logic             servo,
  output logic             busy
);

  localparam logic [POS_W-1:0] CENTRE = POS_W'(1) << (POS_W - 1);
  localparam logic [CTR_W-1:0] CENTRE_LEN =
    CTR_W'(pulse_len_f(PL_W'(CENTRE), PL_W'(MIN_PULSE_C), PL_W'(STEP_CYC_C)));

  logic [POS_W-1:0] target_q, target_d;
  logic [POS_W-1:0] cur_q, cur_d;
  logic [CTR_W-1:0] pulse_len_q, pulse_len_d;
  logic             en_q, en_d;
  logic             servo_q, servo_d;
  logic [POS_W-1:0] cur_next;

`ifdef SERVO_SLEW_EN
  logic [POS_W-1:0] gap;
  logic [POS_W-1:0] step;

  always_comb begin
    gap  = (target_q > cur_q) ? (target_q - cur_q) : (cur_q - target_q);
    step = gap;
    if (32'(gap) > SLEW_STEP_C) begin
      step = POS_W'(SLEW_STEP_C);
    end
    cur_next = (target_q > cur_q) ? (cur_q + step) : (cur_q - step);
  end
`else
  assign cur_next = target_q;
`endif

  always_comb begin
    target_d    = target_q;
    cur_d       = cur_q;
    pulse_len_d = pulse_len_q;
    en_d        = en_q;
    if (wr_en) begin
      target_d = wr_pos;
    end
    // Legal parameters keep every pulse length below FRAME_CYC, so it fits the counter width.
    if (boundary) begin
      cur_d       = cur_next;
      pulse_len_d = CTR_W'(pulse_len_f(PL_W'(cur_next), PL_W'(MIN_PULSE_C), PL_W'(STEP_CYC_C)));
      en_d        = en_in;
    end
    servo_d = en_q && (ctr < pulse_len_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q    <= CENTRE;
      cur_q       <= CENTRE;
      pulse_len_q <= CENTRE_LEN;
      en_q        <= 1'b0;
      servo_q     <= 1'b0;
    end else begin
      target_q    <= target_d;
      cur_q       <= cur_d;
      pulse_len_q <= pulse_len_d;
      en_q        <= en_d;
      servo_q     <= servo_d;
    end
  end

  assign servo = servo_q;
  assign busy  = (cur_q != target_q);

endmodule

// File: rtl/servo_bank.sv
// servo_bank: multi-channel servo PWM generator with a shared frame counter and valid/ready writes.
// Define SERVO_SLEW_EN to rate-limit each channel's position change to SLEW_STEP per frame.
module servo_bank #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned POS_W     = 8,
  parameter int unsigned FRAME_CYC = servo_pkg::FRAME_CYC,
  parameter int unsigned MIN_PULSE = servo_pkg::MIN_PULSE,
  parameter int unsigned STEP_CYC  = servo_pkg::STEP_CYC,
  parameter int unsigned SLEW_STEP = servo_pkg::SLEW_STEP
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_valid,
  output logic                                    wr_ready,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
  input  logic [POS_W-1:0]                        wr_pos,
  input  logic [N_CH-1:0]                         en,
  output logic [N_CH-1:0]                         servo,
  output logic [N_CH-1:0]                         busy,
  output logic                                    frame_start
);

  import servo_pkg::*;

  localparam int unsigned CTR_W = $clog2(FRAME_CYC);
  localparam logic [CTR_W-1:0] LAST = CTR_W'(FRAME_CYC - 1);

  if (pulse_len_f(PL_W'((1 << POS_W) - 1), PL_W'(MIN_PULSE), PL_W'(STEP_CYC)) >= PL_W'(FRAME_CYC))
  begin : g_bad_params
    $error("servo_bank: longest pulse does not fit inside the frame");
  end
  if (SLEW_STEP == 0) begin : g_bad_slew
    $error("servo_bank: SLEW_STEP must be nonzero");
  end

  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             boundary;
  logic [N_CH-1:0]  wr_hit;

  assign boundary    = (ctr_q == LAST);
  assign wr_ready    = !boundary;
  assign frame_start = (ctr_q == '0);

  always_comb begin
    ctr_d = ctr_q + CTR_W'(1);
    if (boundary) begin
      ctr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Out-of-range channel indices match no channel: the write is acknowledged and dropped.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign wr_hit[gi] = wr_valid && wr_ready && (32'(wr_ch) == gi);

    servo_channel #(
      .POS_W       (POS_W),
      .CTR_W       (CTR_W),
      .MIN_PULSE_C (MIN_PULSE),
`ifdef SERVO_SLEW_EN
      .SLEW_STEP_C (SLEW_STEP),
`endif
      .STEP_CYC_C  (STEP_CYC)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .boundary (boundary),
      .wr_en    (wr_hit[gi]),
      .wr_pos   (wr_pos),
      .en_in    (en[gi]),
      .ctr      (ctr_q),
      .servo    (servo[gi]),
      .busy     (busy[gi])
    );
  end

endmodule

// File: tb/tb_servo_bank.sv
// tb_servo_bank: randomized scoreboard bench; a frame-level reference model predicts each frame's pulses.
module tb_servo_bank;

  localparam int N_CH  = 5;
  localparam int POS_W = 8;
  localparam int FRAME = 700;
  localparam int MINP  = 40;
  localparam int STEP  = 2;
  localparam int SLEW  = 4;
  localparam int CH_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [POS_W-1:0]  wr_pos = '0;
  logic [N_CH-1:0]   en = '0;
  logic [N_CH-1:0]   servo;
  logic [N_CH-1:0]   busy;
  logic              frame_start;

  servo_bank #(
    .N_CH(N_CH), .POS_W(POS_W), .FRAME_CYC(FRAME),
    .MIN_PULSE(MINP), .STEP_CYC(STEP), .SLEW_STEP(SLEW)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_pos(wr_pos), .en(en), .servo(servo),
    .busy(busy), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int frames = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // ---------------- reference model (frame-level rules) ----------------
  typedef logic [N_CH-1:0][15:0] plv_t;
  plv_t        exp_q[$];
  int          m_ctr = 0;
  int          m_tgt[N_CH];
  int          m_cur[N_CH];
  logic [N_CH-1:0] m_en = '0;
  bit          m_live = 1'b0;
  int          rst_epoch = 0;

  function automatic int step_toward(int cur, int tgt);
`ifdef SERVO_SLEW_EN
    int d;
    d = tgt - cur;
    if (d > SLEW) d = SLEW;
    if (d < -SLEW) d = -SLEW;
    return cur + d;
`else
    return tgt;
`endif
  endfunction

  function automatic plv_t frame_exp();
    plv_t v;
    for (int c = 0; c < N_CH; c++) begin
      v[c] = m_en[c] ? 16'(MINP + m_cur[c] * STEP) : 16'd0;
    end
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ctr = 0;
        m_en  = '0;
        for (int c = 0; c < N_CH; c++) begin
          m_tgt[c] = 128;
          m_cur[c] = 128;
        end
        exp_q.delete();
        exp_q.push_back(frame_exp());
        rst_epoch++;
        m_live = 1'b1;
      end else begin
        if (wr_valid && m_ctr != FRAME - 1) begin
          $display("write ch=%0d pos=%0d ctr=%0d %s", wr_ch, wr_pos, m_ctr,
                   (int'(wr_ch) < N_CH) ? "applied" : "ignored");
          if (int'(wr_ch) < N_CH) m_tgt[wr_ch] = int'(wr_pos);
        end
        if (m_ctr == FRAME - 1) begin
          m_ctr = 0;
          m_en  = en;
          for (int c = 0; c < N_CH; c++) m_cur[c] = step_toward(m_cur[c], m_tgt[c]);
          exp_q.push_back(frame_exp());
        end else begin
          m_ctr++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int   off;
    bit   open;
    int   seen_epoch;
    plv_t cur_exp;
    int   hi[N_CH];
    int   first[N_CH];
    int   last[N_CH];
    logic [N_CH-1:0] busy_req;
    off = 0;
    open = 1'b0;
    seen_epoch = 0;
    cur_exp = '0;
    forever begin
      @(negedge clk);
      if (!m_live) continue;
      for (int c = 0; c < N_CH; c++) busy_req[c] = (m_cur[c] != m_tgt[c]);
      chk("frame_start", 32'(frame_start), 32'(m_ctr == 0));
      chk("wr_ready", 32'(wr_ready), 32'(m_ctr != FRAME - 1));
      chk("busy", 32'(busy), 32'(busy_req));
      if (frame_start === 1'b1) begin
        if (open && seen_epoch == rst_epoch) begin
          chk("frame_period", 32'(off + 1), 32'(FRAME));
          for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("pulse_len_ch%0d", c), 32'(hi[c]), 32'(cur_exp[c]));
            if (cur_exp[c] != 0) begin
              chk($sformatf("rise_ch%0d", c), 32'(first[c]), 32'd1);
              chk($sformatf("fall_ch%0d", c), 32'(last[c]), 32'(cur_exp[c]));
            end
          end
          frames++;
        end
        seen_epoch = rst_epoch;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL exp_queue actual=empty required=entry");
          open = 1'b0;
        end else begin
          cur_exp = exp_q.pop_front();
          open = 1'b1;
        end
        off = 0;
        for (int c = 0; c < N_CH; c++) begin
          hi[c] = 0;
          first[c] = 0;
          last[c] = 0;
        end
      end else begin
        off++;
        for (int c = 0; c < N_CH; c++) begin
          if (servo[c] === 1'b1) begin
            hi[c]++;
            if (first[c] == 0) first[c] = off;
            last[c] = off;
          end
        end
        if (open && off > FRAME + 5) begin
          chk("frame_start_missing", 32'(off), 32'(FRAME));
          open = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ctr(input int c);
    for (int i = 0; i < FRAME + 2 && m_ctr != c; i++) @(negedge clk);
  endtask

  task automatic write(input int ch, input int pos);
    bit acc;
    wr_valid = 1'b1;
    wr_ch    = CH_W'(ch);
    wr_pos   = POS_W'(pos);
    for (int i = 0; i < 3; i++) begin
      acc = (m_ctr != FRAME - 1);
      @(negedge clk);
      if (acc) break;
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cyc(4);
    chk("rst_servo", 32'(servo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_frame_start", 32'(frame_start), 32'd1);
    rst = 1'b0;

    en = '1;
    cyc(FRAME * 3);

    write(1, 255);
    write(2, 0);
    cyc(FRAME * 2);

    write(0, 140);
    cyc(FRAME * 4);

    // wr_valid held across the boundary cycle
    wait_ctr(FRAME - 1);
    wr_valid = 1'b1;
    wr_ch    = 3'd3;
    wr_pos   = 8'd77;
    chk("hold_ready_boundary", 32'(wr_ready), 32'd0);
    cyc(1);
    chk("hold_ready_after", 32'(wr_ready), 32'd1);
    cyc(1);
    wr_valid = 1'b0;
    chk("hold_accepted_busy3", 32'(busy[3]), 32'd1);
    cyc(FRAME);

    // en[2] dropped in the middle of its pulse
    wait_ctr(20);
    en[2] = 1'b0;
    cyc(FRAME * 2);
    en[2] = 1'b1;

    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(0, 3)) begin
        cyc($urandom_range(1, 150));
        write($urandom_range(0, 7), $urandom_range(0, 255));
      end
      if ($urandom_range(0, 2) == 0) begin
        wait_ctr(FRAME - $urandom_range(1, 3));
        write($urandom_range(0, 7), $urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) en = N_CH'($urandom);
      wait_ctr(0);
      cyc(1);
    end
    en = '1;

    // out-of-range channel: acknowledged and dropped
    wait_ctr(5);
    wr_valid = 1'b1;
    wr_ch    = 3'd5;
    wr_pos   = 8'd9;
    chk("oor_ready", 32'(wr_ready), 32'd1);
    cyc(1);
    wr_valid = 1'b0;
    cyc(FRAME * 2);

    // reset in the middle of a pulse
    wait_ctr(0);
    cyc(10);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_servo", 32'(servo), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc(FRAME * 3);

    cyc(FRAME);
    chk("frames_checked_min25", 32'(frames >= 25), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
